lut_ram_dp_be: RTL and testbench

LUT_RAM_DP_BE -- requirements
Module: lut_ram_dp_be

---
 rtl/lut_ram_dp_be.sv | 121 ++++++++++++
 tb/tb_lut_ram_dp_be.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_dp_be.sv
// rtl/lut_ram_dp_be.sv - simple dual-port LUT RAM with byte enables and post-reset clear sweep
// One write port, one read port; memory contents are zeroed by a DEPTH-cycle sweep after reset.
module lut_ram_dp_be #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2048,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     sweep_cnt;
  logic              clr_we;
  logic              user_we;
  logic              user_re;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_word;
  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (sweep_cnt == LAST_ADDR) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy    = (state == ST_CLEAR);
    clr_we  = (state == ST_CLEAR) && !reset;
    user_we = (state == ST_READY) && !reset && wr_en;
    user_re = (state == ST_READY) && !reset && rd_en;
  end

  // The counter parks on the last address so it never wraps back into the array.
  always_ff @(posedge clk) begin
    if (reset)
      sweep_cnt <= '0;
    else if (state == ST_CLEAR && sweep_cnt != LAST_ADDR)
      sweep_cnt <= sweep_cnt + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[sweep_cnt] <= '0;
    end else if (user_we) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write-first forwarding merges only the enabled bytes onto the stored word.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && user_we && wr_addr == rd_addr) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= user_re;
      if (user_re) s1_data <= rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic             s2_valid;
      logic [WIDTH-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_lut_ram_dp_be.sv
// tb/tb_lut_ram_dp_be.sv - scoreboard bench for lut_ram_dp_be, two configurations driven in lockstep
// dut0: latency 1 read-first; dut1: latency 2 write-first.
module tb_lut_ram_dp_be;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [3:0]       wr_be = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             rd_valid0, rd_valid1;
  logic             busy0, busy1;

  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  exp_t             q0[$];
  exp_t             q1[$];
  logic [WIDTH-1:0] last0 = '0;
  logic [WIDTH-1:0] last1 = '0;

  lut_ram_dp_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .busy(busy0)
  );

  lut_ram_dp_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_valid actual=%h required=no_pulse cyc=%0d", rd_data0, cyc);
      end else begin
        e = q0.pop_front();
        if (rd_data0 !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL dut0_read actual=%h@%0d required=%h@%0d", rd_data0, cyc, e.data, e.cyc);
        end
        last0 = e.data;
      end
    end
    if (rd_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_valid actual=%h required=no_pulse cyc=%0d", rd_data1, cyc);
      end else begin
        e = q1.pop_front();
        if (rd_data1 !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL dut1_read actual=%h@%0d required=%h@%0d", rd_data1, cyc, e.data, e.cyc);
        end
        last1 = e.data;
      end
    end
  end

  // One clock of stimulus; expected read results are queued at issue time.
  task automatic op(input bit w, input int wa, input logic [WIDTH-1:0] wd, input logic [3:0] be,
                    input bit r, input int ra, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1);
    exp_t t;
    wr_en   = w;
    wr_addr = wa[AW-1:0];
    wr_data = wd;
    wr_be   = be;
    rd_en   = r;
    rd_addr = ra[AW-1:0];
    if (r) begin
      t.data = e0; t.cyc = cyc + 1; q0.push_back(t);
      t.data = e1; t.cyc = cyc + 2; q1.push_back(t);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic sweep_count();
    int n0 = 0;
    int n1 = 0;
    int guard = 0;
    while ((busy0 || busy1) && guard < DEPTH * 4) begin
      if (busy0) n0++;
      if (busy1) n1++;
      guard++;
      @(negedge clk);
    end
    chk("busy_len_dut0", n0, DEPTH);
    chk("busy_len_dut1", n1, DEPTH);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy0", busy0, 1);
    chk("reset_busy1", busy1, 1);
    chk("reset_valid0", rd_valid0, 0);
    chk("reset_valid1", rd_valid1, 0);
    chk("reset_data0", rd_data0, 0);
    chk("reset_data1", rd_data1, 0);
    reset = 1'b0;
    sweep_count();

    for (int a = 0; a < DEPTH; a++) op(0, 0, 0, 0, 1, a, 0, 0);

    op(1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
    op(1, 5, 32'h11223344, 4'h5, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 5, 32'hAA22CC44, 32'hAA22CC44);

    op(1, 7, 32'h1, 4'hF, 0, 0, 0, 0);
    op(1, 7, 32'h2, 4'hF, 1, 7, 32'h1, 32'h2);

    op(1, 9, 32'h12345678, 4'hF, 0, 0, 0, 0);
    op(1, 9, 32'hFFFFFFFF, 4'h2, 1, 9, 32'h12345678, 32'h1234FF78);
    op(0, 0, 0, 0, 1, 9, 32'h1234FF78, 32'h1234FF78);

    op(1, 5, 32'h0, 4'h0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 5, 32'hAA22CC44, 32'hAA22CC44);

    op(1, 3, 32'hDEADBEEF, 4'hF, 1, 5, 32'hAA22CC44, 32'hAA22CC44);
    op(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);

    // A write landing while a read to the same word is in flight must not change it.
    op(0, 0, 0, 0, 1, 7, 32'h2, 32'h2);
    op(1, 7, 32'h3, 4'hF, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 7, 32'h3, 32'h3);

    op(0, 0, 0, 0, 1, 0, 0, 0);
    op(0, 0, 0, 0, 1, 1, 0, 0);
    op(0, 0, 0, 0, 1, 2, 0, 0);
    op(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF);

    repeat (4) @(negedge clk);
    chk("hold_valid0", rd_valid0, 0);
    chk("hold_valid1", rd_valid1, 0);
    chk("hold_data0", rd_data0, last0);
    chk("hold_data1", rd_data1, last1);
    chk("hold_value1", last1, 32'hDEADBEEF);

    // Mid-sweep reset with user traffic asserted throughout CLEAR.
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 1;
    wr_en   = 1'b1;
    wr_addr = 0;
    wr_data = 32'hFFFFFFFF;
    wr_be   = 4'hF;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_reset_busy0", busy0, 1);
      chk("held_reset_busy1", busy1, 1);
    end
    reset = 1'b0;
    sweep_count();
    wr_en = 1'b0;
    rd_en = 1'b0;
    op(0, 0, 0, 0, 1, 0, 0, 0);
    op(0, 0, 0, 0, 1, 1, 0, 0);

    // Reset while dut1 still has a read in flight.
    op(1, 3, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
    begin
      exp_t t;
      rd_en   = 1'b1;
      rd_addr = 3;
      t.data = 32'hCAFEF00D; t.cyc = cyc + 1; q0.push_back(t);
      @(negedge clk);
      rd_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("flush_valid1", rd_valid1, 0);
      chk("flush_data1", rd_data1, 0);
      chk("flush_data0", rd_data0, 0);
      @(negedge clk);
      chk("flush_valid1_late", rd_valid1, 0);
      reset = 1'b0;
    end
    sweep_count();

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
